// File: rtl/sample_capture_fifo.sv
// Capture FIFO for strobed filter samples, drained over a valid/ready handshake.
// Optional build macro CAPTURE_OVF_COUNT_EN adds a saturating dropped-sample counter.
module sample_capture_fifo #(
  parameter int DATA_IN_LEN = 10,
  parameter int DEPTH_LOG2  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_IN_LEN-1:0] data_in,
  input  logic                   strobe_in,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_IN_LEN-1:0] rd_data,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow,
  input  logic                   ovf_clear,
  output logic [7:0]             ovf_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH-1:0][DATA_IN_LEN-1:0] mem;
  logic [DEPTH_LOG2-1:0]             wr_ptr, rd_ptr;
  logic                              push, pop, drop;

  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push     = strobe_in & ((level < LVL_FULL) | pop);
  assign drop     = strobe_in & ~push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

`ifdef CAPTURE_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count <= 8'd0;
    else if (drop) begin
      if (ovf_clear)                ovf_count <= 8'd1;
      else if (ovf_count != 8'hFF)  ovf_count <= ovf_count + 8'd1;
    end else if (ovf_clear) ovf_count <= 8'd0;
  end
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_sample_capture_fifo.sv
// Directed bench for sample_capture_fifo: scoreboard queue fed by stimulus, checked by a read monitor.
module tb_sample_capture_fifo;

  localparam int W  = 10;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data_in;
  logic          strobe_in;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [DL:0]   level;
  logic          overflow;
  logic          ovf_clear;
  logic [7:0]    ovf_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];

`ifdef CAPTURE_OVF_COUNT_EN
  localparam int CNT3 = 3;
  localparam int CNT1 = 1;
`else
  localparam int CNT3 = 0;
  localparam int CNT1 = 0;
`endif

  sample_capture_fifo #(.DATA_IN_LEN(W), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .strobe_in(strobe_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .overflow(overflow), .ovf_clear(ovf_clear), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted read must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_read: got 0x%0h expected no data", rd_data);
      end else chk("read_data", 32'(rd_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [W-1:0] d, input bit accepted);
    data_in = d; strobe_in = 1'b1;
    if (accepted) sb.push_back(d);
    tick();
    strobe_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    rd_ready = 1'b1;
    while (level != '0 && n < 20) begin tick(); n++; end
    rd_ready = 1'b0;
    chk({name, "_drained"}, 32'(level), 32'd0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; strobe_in = 1'b0; rd_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data",  32'(rd_data), 0);
    chk("rst_level",    32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);

    // single sample
    strobe(10'h3A5, 1'b1);
    chk("single_valid", 32'(rd_valid), 1);
    chk("single_data",  32'(rd_data), 32'h3A5);
    chk("single_level", 32'(level), 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("single_level_after", 32'(level), 0);
    chk("single_valid_after", 32'(rd_valid), 0);

    // order and wrap
    for (int i = 1; i <= 4; i++) strobe(W'(i), 1'b1);
    chk("wrap_peak_level", 32'(level), 4);
    rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
    chk("wrap_level_2", 32'(level), 2);
    strobe(10'd5, 1'b1);
    strobe(10'd6, 1'b1);
    chk("wrap_level_4", 32'(level), 4);
    drain("wrap");
    chk("wrap_overflow", 32'(overflow), 0);

    // overflow: 4 kept, 3 dropped
    for (int i = 0; i < 4; i++) strobe(W'(10'h101 + i), 1'b1);
    strobe(10'h2AA, 1'b0);
    strobe(10'h2AB, 1'b0);
    strobe(10'h2AC, 1'b0);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count3", 32'(ovf_count), CNT3);
    drain("ovf");
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    chk("ovf_count_cleared", 32'(ovf_count), 0);

    // drop and clear in the same cycle: set wins
    for (int i = 0; i < 4; i++) strobe(W'(10'h0C0 + i), 1'b1);
    ovf_clear = 1'b1; strobe(10'h3FF, 1'b0); ovf_clear = 1'b0;
    chk("drop_clr_flag", 32'(overflow), 1);
    chk("drop_clr_count", 32'(ovf_count), CNT1);
    drain("drop_clr");
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) strobe(W'(10'h011 + i), 1'b1);
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 10'h155; strobe_in = 1'b1; sb.push_back(10'h155);
      tick();
    end
    strobe_in = 1'b0; rd_ready = 1'b0;
    chk("full_pp_level", 32'(level), 4);
    chk("full_pp_overflow", 32'(overflow), 0);
    drain("full_pp");

    // empty: strobe with rd_ready, no bypass
    rd_ready = 1'b1; data_in = 10'h2D2; strobe_in = 1'b1; sb.push_back(10'h2D2);
    #3 chk("nobypass_valid_same", 32'(rd_valid), 0);
    tick(); strobe_in = 1'b0;
    chk("nobypass_valid_next", 32'(rd_valid), 1);
    tick(); rd_ready = 1'b0;
    chk("nobypass_level", 32'(level), 0);

    // async reset mid-stream
    strobe(10'h0A1, 1'b1);
    strobe(10'h0A2, 1'b1);
    strobe(10'h0A3, 1'b1);
    chk("arst_pre_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_data",  32'(rd_data), 0);
    chk("arst_level",    32'(level), 0);
    chk("arst_overflow", 32'(overflow), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    strobe(10'h3C3, 1'b1);
    chk("arst_first_data", 32'(rd_data), 32'h3C3);
    drain("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
